// File: rtl/mem_req_queue_if.sv
// Handshake bundle between the arbiter/dcache/memory and mem_req_queue.
// slave: the queue itself; master: the surrounding environment.
interface mem_req_queue_if #(
  parameter int ADDR_BITS  = 28,
  parameter int TAG_BITS   = 5,
  parameter int DATA_BITS  = 128,
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 8
);
  logic                          in_req_valid;
  logic                          in_req_ready;
  logic                          in_req_rw;
  logic [ADDR_BITS-1:0]          in_req_addr;
  logic [TAG_BITS-1:0]           in_req_tag;
  logic                          in_data_valid;
  logic                          in_data_ready;
  logic [DATA_BITS-1:0]          in_data_bits;
  logic [DATA_BITS/8-1:0]        in_data_mask;
  logic                          out_req_valid;
  logic                          out_req_ready;
  logic                          out_req_rw;
  logic [ADDR_BITS-1:0]          out_req_addr;
  logic [TAG_BITS-1:0]           out_req_tag;
  logic                          out_data_valid;
  logic                          out_data_ready;
  logic [DATA_BITS-1:0]          out_data_bits;
  logic [DATA_BITS/8-1:0]        out_data_mask;
  logic [$clog2(CMD_DEPTH):0]    cmd_count;
  logic [$clog2(DATA_DEPTH):0]   data_count;

  modport slave (
    input  in_req_valid, in_req_rw, in_req_addr, in_req_tag,
    input  in_data_valid, in_data_bits, in_data_mask,
    input  out_req_ready, out_data_ready,
    output in_req_ready, in_data_ready,
    output out_req_valid, out_req_rw, out_req_addr, out_req_tag,
    output out_data_valid, out_data_bits, out_data_mask,
    output cmd_count, data_count
  );

  modport master (
    output in_req_valid, in_req_rw, in_req_addr, in_req_tag,
    output in_data_valid, in_data_bits, in_data_mask,
    output out_req_ready, out_data_ready,
    input  in_req_ready, in_data_ready,
    input  out_req_valid, out_req_rw, out_req_addr, out_req_tag,
    input  out_data_valid, out_data_bits, out_data_mask,
    input  cmd_count, data_count
  );
endinterface

// File: rtl/mem_req_queue.sv
// Elastic command/write-data buffer between cache arbiter and main memory.
// Optional MEM_REQ_QUEUE_BYPASS_EN: reads skip an empty command FIFO combinationally.
module mem_req_queue #(
  parameter int ADDR_BITS  = 28,
  parameter int TAG_BITS   = 5,
  parameter int DATA_BITS  = 128,
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 8,
  parameter int DATA_BEATS = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_queue_if.slave    bus
);
  localparam int CW        = $clog2(CMD_DEPTH);
  localparam int DW        = $clog2(DATA_DEPTH);
  localparam int MW        = DATA_BITS / 8;
  localparam int CMD_BITS  = 1 + ADDR_BITS + TAG_BITS;
  localparam int BEAT_BITS = DATA_BITS + MW;
  localparam logic [DW:0] BEATS     = (DW+1)'(DATA_BEATS);
  localparam logic [CW:0] CMD_FULL  = (CW+1)'(CMD_DEPTH);
  localparam logic [DW:0] DATA_FULL = (DW+1)'(DATA_DEPTH);

  logic [CMD_BITS-1:0]  cmd_mem  [CMD_DEPTH];
  logic [BEAT_BITS-1:0] beat_mem [DATA_DEPTH];

  logic [CW-1:0] cmd_wr_ptr, cmd_rd_ptr;
  logic [CW:0]   cmd_cnt;
  logic [DW-1:0] data_wr_ptr, data_rd_ptr;
  logic [DW:0]   data_cnt;
  logic [DW:0]   credit;
  logic [DW:0]   pend_beats;

  logic [CMD_BITS-1:0] cmd_head;
  logic                fifo_req_valid;
  logic                bypass;
  logic                in_req_fire, out_req_fire, in_data_fire, out_data_fire;
  logic                cmd_push, cmd_pop, wr_issue;

  always_comb begin
    cmd_head       = cmd_mem[cmd_rd_ptr];
    // A write head waits until every one of its beats is buffered and unclaimed.
    fifo_req_valid = (cmd_cnt != '0) && (!cmd_head[CMD_BITS-1] || credit >= BEATS);

    bus.in_req_ready  = !reset && (cmd_cnt != CMD_FULL);
    bus.in_data_ready = !reset && (data_cnt != DATA_FULL);

`ifdef MEM_REQ_QUEUE_BYPASS_EN
    bypass = !reset && (cmd_cnt == '0) && bus.in_req_valid && !bus.in_req_rw;
    if (bypass) begin
      bus.out_req_rw   = bus.in_req_rw;
      bus.out_req_addr = bus.in_req_addr;
      bus.out_req_tag  = bus.in_req_tag;
    end else begin
      {bus.out_req_rw, bus.out_req_addr, bus.out_req_tag} = cmd_head;
    end
`else
    bypass = 1'b0;
    {bus.out_req_rw, bus.out_req_addr, bus.out_req_tag} = cmd_head;
`endif
    bus.out_req_valid = !reset && (fifo_req_valid || bypass);

    bus.out_data_valid = !reset && (data_cnt != '0) && (pend_beats != '0);
    {bus.out_data_mask, bus.out_data_bits} = beat_mem[data_rd_ptr];

    bus.cmd_count  = cmd_cnt;
    bus.data_count = data_cnt;

    in_req_fire   = bus.in_req_valid   && bus.in_req_ready;
    out_req_fire  = bus.out_req_valid  && bus.out_req_ready;
    in_data_fire  = bus.in_data_valid  && bus.in_data_ready;
    out_data_fire = bus.out_data_valid && bus.out_data_ready;

    // A bypassed read that is taken immediately never touches the FIFO.
    cmd_push = in_req_fire && !(bypass && bus.out_req_ready);
    cmd_pop  = out_req_fire && !bypass;
    wr_issue = out_req_fire && bus.out_req_rw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wr_ptr  <= '0;
      cmd_rd_ptr  <= '0;
      cmd_cnt     <= '0;
      data_wr_ptr <= '0;
      data_rd_ptr <= '0;
      data_cnt    <= '0;
      credit      <= '0;
      pend_beats  <= '0;
    end else begin
      if (cmd_push)      cmd_wr_ptr  <= cmd_wr_ptr + CW'(1);
      if (cmd_pop)       cmd_rd_ptr  <= cmd_rd_ptr + CW'(1);
      if (in_data_fire)  data_wr_ptr <= data_wr_ptr + DW'(1);
      if (out_data_fire) data_rd_ptr <= data_rd_ptr + DW'(1);
      cmd_cnt    <= cmd_cnt + (CW+1)'(cmd_push) - (CW+1)'(cmd_pop);
      data_cnt   <= data_cnt + (DW+1)'(in_data_fire) - (DW+1)'(out_data_fire);
      credit     <= credit + (DW+1)'(in_data_fire) - (wr_issue ? BEATS : '0);
      pend_beats <= pend_beats + (wr_issue ? BEATS : '0) - (DW+1)'(out_data_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push)
      cmd_mem[cmd_wr_ptr] <= {bus.in_req_rw, bus.in_req_addr, bus.in_req_tag};
    if (in_data_fire)
      beat_mem[data_wr_ptr] <= {bus.in_data_mask, bus.in_data_bits};
  end
endmodule

// File: doc/mem_req_queue.md
Name: mem_req_queue

Overview:
- Elastic request buffer between the cache arbiter and main memory.
- Queues arbiter read/write commands (rw, addr, tag) and dcache write-data beats in two FIFOs.
- A write command is released to memory only once all of its data beats are buffered; a beat is released only after its owning command has issued.
- Decouples arbiter timing from memory back-pressure. The response path (mem_resp_*) bypasses this block entirely.

Parameters:
- ADDR_BITS, 28: command address width (matches MEM_ADDR_BITS).
- TAG_BITS, 5: request tag width (matches MEM_TAG_BITS).
- DATA_BITS, 128: write beat width (matches MEM_DATA_BITS); mask width is DATA_BITS/8.
- CMD_DEPTH, 4: command FIFO entries; power of 2, at least 2.
- DATA_DEPTH, 8: data FIFO entries; power of 2, at least DATA_BEATS.
- DATA_BEATS, 4: data beats per write command; at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_req_valid  in  1  arbiter command valid.
- in_req_ready  out  1  command FIFO can accept.
- in_req_rw  in  1  1=write, 0=read.
- in_req_addr  in  ADDR_BITS  command address.
- in_req_tag  in  TAG_BITS  command tag.
- in_data_valid  in  1  write beat valid.
- in_data_ready  out  1  data FIFO can accept.
- in_data_bits  in  DATA_BITS  write beat.
- in_data_mask  in  DATA_BITS/8  byte mask.
- out_req_valid  out  1  command to memory valid.
- out_req_ready  in  1  memory accepts command.
- out_req_rw  out  1  command rw.
- out_req_addr  out  ADDR_BITS  command address.
- out_req_tag  out  TAG_BITS  command tag.
- out_data_valid  out  1  beat to memory valid.
- out_data_ready  in  1  memory accepts beat.
- out_data_bits  out  DATA_BITS  beat data.
- out_data_mask  out  DATA_BITS/8  beat mask.
- cmd_count  out  log2(CMD_DEPTH)+1  command FIFO occupancy.
- data_count  out  log2(DATA_DEPTH)+1  data FIFO occupancy.

Behaviour:
- Fire conditions: any handshake fires on valid && ready at a rising edge.
- Reset: read/write pointers, cmd_count, data_count, credit and pend_beats all go to 0.
  - While reset is high: in_req_ready=0, in_data_ready=0, out_req_valid=0, out_data_valid=0.
  - Readies rise in the first cycle after reset deasserts.
  - Reset mid-operation discards all queued commands and beats; memory sees no partial write.
- in_req_ready = (cmd_count != CMD_DEPTH). in_data_ready = (data_count != DATA_DEPTH).
  - Both depend only on registered occupancy.
  - Full plus simultaneous dequeue does not accept in the same cycle.
- Pointers wrap modulo depth; counts distinguish full from empty.
- credit counter: beats buffered but not yet claimed by an issued write.
  - Increments by 1 per in_data fire.
  - Decrements by DATA_BEATS per write out_req fire.
  - Both events in one cycle apply the net change.
  - Range 0..DATA_DEPTH.
- pend_beats counter: beats owed by issued writes.
  - Increments by DATA_BEATS on write out_req fire.
  - Decrements by 1 per out_data fire.
  - Simultaneous events apply the net change.
- out_req_valid = (cmd_count != 0) && (head.rw == 0 || credit >= DATA_BEATS).
  - A read at head is never blocked by data.
  - Commands issue strictly in FIFO order; a write head blocks the reads behind it.
- out_data_valid = (data_count != 0) && (pend_beats != 0).
  - Beats leave in arrival order.
  - The first beat may fire in the same cycle its command fires only if pend_beats is already nonzero.
  - Otherwise it fires one cycle after the command.
- out_req_* and out_data_* fields come from the FIFO head and hold stable while valid && !ready.
- Latency (bypass off): input fire at cycle N produces output valid at N+1 at the earliest.
- Full throughput: one command and one beat per cycle sustained.
- Extra beats beyond claimed writes wait indefinitely; the bench must not over-supply.
- Stray beats never cause a write to issue early. Credit saturates at DATA_DEPTH by construction.

Optional Feature:
- Macro MEM_REQ_QUEUE_BYPASS_EN.
- When defined, command path:
  - If the command FIFO is empty, in_req_valid is high, and the command is a read, out_req_* is driven combinationally from in_req_*.
  - If out_req_ready is also high, the command is consumed without being written to the FIFO (0-cycle latency).
  - Under bypass, in_req_ready also asserts when cmd_count == 0.
  - Writes never bypass.
- When undefined: no combinational path from in_* to out_*; 1-cycle minimum latency.

Test Plan:
- Reset held 3 cycles with in_req_valid=1 -> no fires; first cycle after reset in_req_ready=1, cmd_count=0, all out valids 0.
- Reads tags 1,2,3 back-to-back, out_req_ready=1 -> tags 1,2,3 emitted on consecutive cycles starting 1 cycle after the first enqueue (0 cycles with bypass on for tag 1).
- Write addr 0x40 tag 5 presented, then 4 beats 0xA..0xD one per cycle -> out_req_valid stays 0 until the 4th beat is buffered; then the command issues, followed by beats 0xA..0xD in order.
- out_req_ready=0, 5 reads offered with CMD_DEPTH=4 -> 4 accepted, in_req_ready=0, cmd_count=4; raise ready -> 4 drain in order, 5th then accepted.
- Write tag 7 (beats buffered) then read tag 8, out_data_ready=0 -> both commands issue, out_data_valid stays high with beat 0 held stable until ready rises.
- Reset asserted after 2 of 4 beats of a write -> memory sees no command or beat; data_count=0 after reset.
